ysyx_22050133_lsu: RTL and testbench

YSYX_22050133_LSU -- requirements
Module: ysyx_22050133_lsu

---
 rtl/ysyx_22050133_lsu.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_22050133_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_lsu.sv
// Load/store unit: turns one EXU memory op into a doubleword memory access,
// lane-aligns store data and extends load data, with misalign/illegal/timeout errors.
module ysyx_22050133_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the valid side holds its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, MREQ = 2'd1, MWAIT = 2'd2, RESP = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  logic        wen_q, wen_d;
  logic [2:0]  f3_q, f3_d, off_q, off_d;
  logic        mem_valid_d, mem_wen_d, resp_valid_d;
  logic [63:0] mem_addr_d, mem_wdata_d, resp_rdata_d;
  logic [7:0]  mem_wmask_d, size_mask;
  logic [1:0]  resp_err_d;
  logic        illegal, misaligned, tmo;
  logic [63:0] lsh, ext;

  assign req_ready = (state_q == IDLE) && !rst;
  assign dbg_state = state_q;

  assign cnt_inc = cnt_q + 32'd1;
  assign tmo     = (TIMEOUT != 0) && (cnt_inc >= TIMEOUT);

  always_comb begin
    illegal = req_wen ? req_funct3[2] : (req_funct3 == 3'b111);
    case (req_funct3[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Load data arrives as a full doubleword; bring the addressed bytes to bit 0.
  always_comb begin
    lsh = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{56{lsh[7]}}, lsh[7:0]};
      3'b001:  ext = {{48{lsh[15]}}, lsh[15:0]};
      3'b010:  ext = {{32{lsh[31]}}, lsh[31:0]};
      3'b011:  ext = lsh;
      3'b100:  ext = {56'd0, lsh[7:0]};
      3'b101:  ext = {48'd0, lsh[15:0]};
      3'b110:  ext = {32'd0, lsh[31:0]};
      default: ext = 64'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wen_d        = wen_q;
    f3_d         = f3_q;
    off_d        = off_q;
    mem_valid_d  = mem_valid;
    mem_addr_d   = mem_addr;
    mem_wen_d    = mem_wen;
    mem_wmask_d  = mem_wmask;
    mem_wdata_d  = mem_wdata;
    resp_valid_d = resp_valid;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d = req_wen;
          f3_d  = req_funct3;
          off_d = req_addr[2:0];
          if (illegal || misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 64'd0;
            resp_err_d   = illegal ? 2'b11 : 2'b01;
          end else begin
            state_d     = MREQ;
            cnt_d       = 32'd0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[63:3], 3'b000};
            mem_wen_d   = req_wen;
            mem_wmask_d = req_wen ? (size_mask << req_addr[2:0]) : 8'd0;
            mem_wdata_d = req_wen ? (req_wdata << {req_addr[2:0], 3'b000}) : 64'd0;
          end
        end
      end
      MREQ: begin
        // A handshake in the same cycle as the timeout still completes.
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          cnt_d       = cnt_inc;
          if (wen_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 64'd0;
            resp_err_d   = 2'b00;
          end else begin
            state_d = MWAIT;
          end
        end else if (tmo) begin
          mem_valid_d  = 1'b0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = 64'd0;
          resp_err_d   = 2'b10;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MWAIT: begin
        if (mem_rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = ext;
          resp_err_d   = 2'b00;
        end else if (tmo) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = 64'd0;
          resp_err_d   = 2'b10;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      wen_q      <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 3'd0;
      mem_valid  <= 1'b0;
      mem_addr   <= 64'd0;
      mem_wen    <= 1'b0;
      mem_wmask  <= 8'd0;
      mem_wdata  <= 64'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      mem_valid  <= mem_valid_d;
      mem_addr   <= mem_addr_d;
      mem_wen    <= mem_wen_d;
      mem_wmask  <= mem_wmask_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Directed bench for ysyx_22050133_lsu (TIMEOUT=4): latency, lane/extension,
// error paths, timeout, response backpressure and mid-transaction reset.
module tb_ysyx_22050133_lsu;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_valid, mem_ready, mem_wen;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  ysyx_22050133_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble the request inputs.
  task automatic do_accept(input logic wen, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid  = 1'b0;
    req_wen    = ~wen;
    req_funct3 = 3'b111;
    req_addr   = 64'hFFFF_FFFF_FFFF_FFFF;
    req_wdata  = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic consume(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_resp_drop"}, resp_valid, 1'b0);
    check({tag, "_idle"}, dbg_state, 2'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rd, input logic [63:0] exp);
    do_accept(1'b0, f3, addr, 64'd0);
    check({tag, "_mvalid"}, mem_valid, 1'b1);
    check({tag, "_maddr"}, mem_addr, {addr[63:3], 3'b000});
    check({tag, "_mwen"}, mem_wen, 1'b0);
    check({tag, "_wmask"}, mem_wmask, 8'h00);
    check({tag, "_mwdata"}, mem_wdata, 64'd0);
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = ~rd;
    step();
    mem_ready  = 1'b0;
    check({tag, "_mvalid_drop"}, mem_valid, 1'b0);
    check({tag, "_no_early_resp"}, resp_valid, 1'b0);
    mem_rdata  = rd;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h5555_5555_5555_5555;
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_err"}, resp_err, 2'b00);
    consume(tag);
  endtask

  task automatic do_error(input string tag, input logic wen, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [1:0] exp_err);
    do_accept(wen, f3, addr, 64'h1111);
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_err"}, resp_err, exp_err);
    check({tag, "_rdata"}, resp_rdata, 64'd0);
    check({tag, "_no_mem"}, mem_valid, 1'b0);
    consume(tag);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0;
    req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    step();
    step();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wmask", mem_wmask, 8'd0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", resp_err, 2'd0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1'b1);

    // SH with one cycle of memory stall
    do_accept(1'b1, 3'b001, 64'h8000_0002, 64'h1234);
    check("sh_mvalid", mem_valid, 1'b1);
    check("sh_req_ready", req_ready, 1'b0);
    check("sh_maddr", mem_addr, 64'h8000_0000);
    check("sh_mwen", mem_wen, 1'b1);
    check("sh_wmask", mem_wmask, 8'h0C);
    check("sh_wdata", mem_wdata, 64'h0000_0000_1234_0000);
    step();
    check("sh_hold_mvalid", mem_valid, 1'b1);
    check("sh_hold_wmask", mem_wmask, 8'h0C);
    check("sh_hold_wdata", mem_wdata, 64'h0000_0000_1234_0000);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("sh_resp_valid", resp_valid, 1'b1);
    check("sh_resp_err", resp_err, 2'b00);
    check("sh_resp_rdata", resp_rdata, 64'd0);
    check("sh_mvalid_drop", mem_valid, 1'b0);
    // request offered during the RESP->IDLE edge must not be taken
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b011; req_addr = 64'h8000_0000;
    resp_ready = 1'b1;
    step();
    req_valid = 1'b0; resp_ready = 1'b0;
    check("sh_no_accept_state", dbg_state, 2'd0);
    check("sh_no_accept_mvalid", mem_valid, 1'b0);

    // loads: byte lanes and extension
    do_load("lb6", 3'b000, 64'h8000_0006, 64'h00FF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    do_load("lb5", 3'b000, 64'h8000_0005, 64'h0000_FF00_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    do_load("lbu0", 3'b100, 64'h8000_0000, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0080);
    do_load("lh2", 3'b001, 64'h8000_0002, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
    do_load("lhu6", 3'b101, 64'h8000_0006, 64'hFFFE_0000_0000_0000, 64'h0000_0000_0000_FFFE);
    do_load("lw4", 3'b010, 64'h8000_0004, 64'h7FFF_FFFF_0000_0000, 64'h0000_0000_7FFF_FFFF);
    do_load("ld0", 3'b011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // error paths
    do_error("lw_mis", 1'b0, 3'b010, 64'h8000_0006, 2'b01);
    do_error("sd_mis", 1'b1, 3'b011, 64'h8000_0004, 2'b01);
    do_error("lh_mis", 1'b0, 3'b001, 64'h8000_0001, 2'b01);
    do_error("ld_ill", 1'b0, 3'b111, 64'h8000_0000, 2'b11);
    do_error("st_ill", 1'b1, 3'b100, 64'h8000_0000, 2'b11);

    // timeout: mem_valid for exactly 4 cycles, then err=10
    do_accept(1'b0, 3'b011, 64'h8000_0008, 64'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) break;
      if (mem_valid) n++;
      step();
    end
    check("tmo_resp_valid", resp_valid, 1'b1);
    check("tmo_mvalid_cycles", 64'(n), 64'd4);
    check("tmo_err", resp_err, 2'b10);
    check("tmo_rdata", resp_rdata, 64'd0);
    check("tmo_mvalid_drop", mem_valid, 1'b0);
    consume("tmo");

    // SB handshake on the last allowed cycle: completion beats timeout
    do_accept(1'b1, 3'b000, 64'h8000_0003, 64'hAB);
    check("sb_wmask", mem_wmask, 8'h08);
    check("sb_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
    step(); step(); step();
    check("sb_still_mvalid", mem_valid, 1'b1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("sb_resp_valid", resp_valid, 1'b1);
    check("sb_err", resp_err, 2'b00);
    consume("sb");

    // LWU with response backpressure
    do_accept(1'b0, 3'b110, 64'h8000_0004, 64'd0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h8000_0001_DEAD_BEEF;
    step();
    mem_rvalid = 1'b0; mem_rdata = 64'd0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b011; req_addr = 64'h8000_0000;
      check("lwu_hold_valid", resp_valid, 1'b1);
      check("lwu_hold_rdata", resp_rdata, 64'h0000_0000_8000_0001);
      check("lwu_hold_err", resp_err, 2'b00);
      check("lwu_req_ready", req_ready, 1'b0);
      step();
    end
    req_valid = 1'b0;
    check("lwu_no_mvalid", mem_valid, 1'b0);
    consume("lwu");

    // reset in MWAIT, then a stale rvalid
    do_accept(1'b0, 3'b010, 64'h8000_0000, 64'd0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("rw_in_mwait", dbg_state, 2'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rw_state", dbg_state, 2'd0);
    check("rw_req_ready", req_ready, 1'b1);
    mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    mem_rvalid = 1'b0;
    check("rw_no_resp", resp_valid, 1'b0);
    check("rw_state_after", dbg_state, 2'd0);
    step();
    check("rw_no_resp2", resp_valid, 1'b0);

    // reset in MREQ drops mem_valid at the next edge
    do_accept(1'b0, 3'b011, 64'h8000_0010, 64'd0);
    check("rq_mvalid", mem_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rq_mvalid_drop", mem_valid, 1'b0);
    check("rq_resp", resp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
